// File: rtl/alu_pkg.sv
// Shared definitions for the ALU, its decoder and the writeback stage:
// opcode constants, flag bit positions, condition encodings, skid states.
package alu_pkg;

  localparam int OPW = 5;

  // Bit positions inside the {Z,N,C,V} flag / status nibble.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [OPW-1:0] OP_NOP = 5'b00000;
  localparam logic [OPW-1:0] OP_CMP = 5'b01110;
  localparam logic [OPW-1:0] OP_TST = 5'b01111;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_LT = 3'd3;
  localparam logic [2:0] COND_GE = 3'd4;
  localparam logic [2:0] COND_CS = 3'd5;
  localparam logic [2:0] COND_CC = 3'd6;
  localparam logic [2:0] COND_MI = 3'd7;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  // Evaluate a branch condition against a status nibble.
  function automatic logic cond_eval(input logic [2:0] sel, input logic [3:0] st);
    logic res;
    case (sel)
      COND_AL: res = 1'b1;
      COND_EQ: res = st[FLAG_Z];
      COND_NE: res = ~st[FLAG_Z];
      COND_LT: res = st[FLAG_N] ^ st[FLAG_V];
      COND_GE: res = ~(st[FLAG_N] ^ st[FLAG_V]);
      COND_CS: res = st[FLAG_C];
      COND_CC: res = ~st[FLAG_C];
      default: res = st[FLAG_N];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Generic two-entry skid buffer. The head register always drives out_data;
// the tail register absorbs one extra record when the consumer stalls, so
// the producer sees in_ready drop one cycle late without losing data.
module wb_skid_buf
  import alu_pkg::*;
#(
  parameter int DW = 21
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  skid_state_t   state;
  logic [DW-1:0] head_q;
  logic [DW-1:0] tail_q;
  logic          ready_q;
  logic          valid_q;
  logic          push;
  logic          pop;

  assign push      = in_valid & ready_q;
  assign pop       = valid_q & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = head_q;

  // Occupancy FSM with registered handshake outputs and data movement.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the two data registers are reset too; they are only two words
      // and a known value keeps out_data clean while out_valid is low.
      state   <= SKID_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        SKID_EMPTY: begin
          ready_q <= 1'b1;
          valid_q <= push;
          if (push) begin
            head_q <= in_data;
            state  <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          ready_q <= ~(push & ~pop);
          valid_q <= ~(pop & ~push);
          if (push && pop) begin
            head_q <= in_data;
          end else if (push) begin
            tail_q <= in_data;
            state  <= SKID_TWO;
          end else if (pop) begin
            state  <= SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          ready_q <= pop;
          valid_q <= 1'b1;
          if (pop) begin
            head_q <= tail_q;
            state  <= SKID_ONE;
          end
        end
        default: begin
          state   <= SKID_EMPTY;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: commits results to the architectural accumulator and
// status register as soon as they are accepted, and forwards the committed
// {ACC, SR, cond} record downstream through a skid buffer so that commit
// stage backpressure never holds up ACC/SR.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_result,
  input  logic [3:0]     alu_flags,
  input  logic [2:0]     cond_sel,
  output logic [W-1:0]   acc,
  output logic [3:0]     sr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_acc,
  output logic [3:0]     out_sr,
  output logic           out_cond
);

  localparam int DW = W + 5;

  logic          accept;
  logic [W-1:0]  acc_next;
  logic [3:0]    sr_next;
  logic          cond_next;
  logic [DW-1:0] rec_in;
  logic [DW-1:0] rec_out;

  assign accept = in_valid & in_ready;

  // Opcode classification: what the accepted record does to ACC and SR.
  // NOTE: both outputs get a default before the case so no path leaves
  // them unassigned, which would otherwise infer a latch.
  always_comb begin
    acc_next = acc;
    sr_next  = sr;
    if (accept) begin
      case (alu_op)
        OP_NOP: ;
        OP_CMP, OP_TST: sr_next = alu_flags;
        default: begin
          acc_next = alu_result;
          sr_next  = alu_flags;
        end
      endcase
    end
  end

  assign cond_next = cond_eval(cond_sel, sr_next);
  assign rec_in    = {acc_next, sr_next, cond_next};

  // Architectural ACC/SR; acc_next/sr_next already hold them when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      sr  <= 4'b0000;
    end else begin
      acc <= acc_next;
      sr  <= sr_next;
    end
  end

  wb_skid_buf #(.DW(DW)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (rec_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (rec_out)
  );

  assign out_acc  = rec_out[DW-1:5];
  assign out_sr   = rec_out[4:1];
  assign out_cond = rec_out[0];

endmodule
